// File: rtl/mv_pkg.sv
// Shared definitions for the sequential matrix-vector multiplier: FSM encoding,
// width helpers and the default geometry used by the wrapper and the bench.
package mv_pkg;
  localparam int N_DEF  = 4;
  localparam int EW_DEF = 2;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_e;

  // Result width: a sum of n products of two ew-bit operands cannot overflow this.
  function automatic int rw_of(input int n, input int ew);
    return 2 * ew + $clog2(n);
  endfunction

  function automatic int iw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int aw_of(input int n);
    return $clog2(n * n);
  endfunction
endpackage

// File: rtl/mv_mult_seq_if.sv
// Matrix load port plus vector-in / result-out valid-ready streams of mv_mult_seq.
interface mv_mult_seq_if
  import mv_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int EW = EW_DEF
);
  localparam int RW = rw_of(N, EW);
  localparam int AW = aw_of(N);

  logic          mat_we;
  logic [AW-1:0] mat_addr;
  logic [EW-1:0] mat_wdata;
  logic          mat_err;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic          out_last;
  logic          busy;

  modport master (
    output mat_we, mat_addr, mat_wdata, in_valid, in_data, out_ready,
    input  mat_err, in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  mat_we, mat_addr, mat_wdata, in_valid, in_data, out_ready,
    output mat_err, in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/mv_mac.sv
// Registered multiply-accumulate. sum is the combinational acc+product so the
// caller can capture a finished dot product in the same cycle it clears acc.
module mv_mac
  import mv_pkg::*;
#(
  parameter int EW     = EW_DEF,
  parameter int RW     = rw_of(N_DEF, EW_DEF),
  parameter bit SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  output logic [RW-1:0] sum
);
  function automatic logic signed [RW-1:0] ext(input logic [EW-1:0] v);
    if (SIGNED) ext = {{(RW-EW){v[EW-1]}}, v};
    else        ext = {{(RW-EW){1'b0}}, v};
  endfunction

  logic signed [RW-1:0] a_ext, b_ext, prod, sum_s;
  logic signed [RW-1:0] acc_q, acc_d;

  always_comb begin
    a_ext = ext(a);
    b_ext = ext(b);
    prod  = a_ext * b_ext;
    sum_s = acc_q + prod;
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = sum_s;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign sum = sum_s;
endmodule

// File: rtl/mv_mult_seq.sv
// Sequential y = M*x: register-held N x N matrix, one time-shared MAC,
// vector streamed in and results streamed out over valid/ready.
module mv_mult_seq
  import mv_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int EW     = EW_DEF,
  parameter bit SIGNED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  mv_mult_seq_if.slave bus
);
  localparam int RW = rw_of(N, EW);
  localparam int IW = iw_of(N);
  localparam int AW = aw_of(N);
  localparam int NN = N * N;

  state_e        state_q, state_d;
  logic [EW-1:0] m_q [NN];
  logic [EW-1:0] m_d [NN];
  logic [EW-1:0] x_q [N];
  logic [EW-1:0] x_d [N];
  logic [RW-1:0] y_q [N];
  logic [RW-1:0] y_d [N];
  logic [IW-1:0] cnt_q, cnt_d, r_q, r_d, c_q, c_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d, busy_q, busy_d;
  logic [RW-1:0] out_data_q, out_data_d;
  logic          mac_en, mac_clr, in_fire, out_fire;
  logic [RW-1:0] mac_sum;
  logic [AW-1:0] mc_idx;

  assign mc_idx = AW'(int'(r_q) * N + int'(c_q));

  mv_mac #(.EW(EW), .RW(RW), .SIGNED(SIGNED)) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (mac_en),
    .clr (mac_clr),
    .a   (m_q[mc_idx]),
    .b   (x_q[c_q]),
    .sum (mac_sum)
  );

  always_comb begin
    in_fire  = in_ready_q && bus.in_valid;
    out_fire = out_valid_q && bus.out_ready;
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    c_d      = c_q;
    m_d      = m_q;
    x_d      = x_q;
    y_d      = y_q;
    mac_en   = 1'b0;
    mac_clr  = 1'b0;

    // The matrix is frozen while products are being formed.
    if (bus.mat_we && state_q != COMPUTE && int'(bus.mat_addr) < NN)
      m_d[bus.mat_addr] = bus.mat_wdata;

    case (state_q)
      IDLE: if (in_fire) begin
        x_d[0]  = bus.in_data;
        cnt_d   = IW'(1);
        state_d = LOAD;
      end
      LOAD: if (in_fire) begin
        x_d[cnt_q] = bus.in_data;
        if (cnt_q == IW'(N-1)) begin
          state_d = COMPUTE;
          cnt_d   = '0;
          r_d     = '0;
          c_d     = '0;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      COMPUTE: begin
        mac_en = 1'b1;
        if (c_q == IW'(N-1)) begin
          mac_clr  = 1'b1;
          y_d[r_q] = mac_sum;
          c_d      = '0;
          if (r_q == IW'(N-1)) begin
            state_d = DRAIN;
            r_d     = '0;
            cnt_d   = '0;
          end else begin
            r_d = r_q + IW'(1);
          end
        end else begin
          c_d = c_q + IW'(1);
        end
      end
      DRAIN: if (out_fire) begin
        if (cnt_q == IW'(N-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state; y[0] is already final on DRAIN entry.
    in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
    out_last_d  = (state_d == DRAIN) && (cnt_d == IW'(N-1));
    out_data_d  = (state_d == DRAIN) ? y_q[cnt_d] : '0;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      m_q         <= '{default: '0};
      x_q         <= '{default: '0};
      y_q         <= '{default: '0};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      c_q         <= c_d;
      m_q         <= m_d;
      x_q         <= x_d;
      y_q         <= y_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.mat_err   = bus.mat_we && (state_q == COMPUTE) && !rst;
endmodule

// File: tb/tb_mv_mult_seq.sv
// Directed bench for mv_mult_seq: an unsigned and a signed instance, expected
// results computed from a matrix model and queued when each vector is sent.
module tb_mv_mult_seq;
  import mv_pkg::*;

  localparam int N  = N_DEF;
  localparam int EW = EW_DEF;
  localparam int RW = rw_of(N, EW);
  localparam int AW = aw_of(N);
  localparam int NN = N * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mv_mult_seq_if #(.N(N), .EW(EW)) bu ();
  mv_mult_seq_if #(.N(N), .EW(EW)) bs ();

  mv_mult_seq #(.N(N), .EW(EW), .SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(bu.slave));
  mv_mult_seq #(.N(N), .EW(EW), .SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bs.slave));

  typedef struct packed {
    logic [RW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    logic          mat_err;
    logic          in_ready;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic [RW-1:0] out_data;
  } obs_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mm[2][NN];
  int   xv[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.mat_err = bu.mat_err; o.in_ready = bu.in_ready; o.out_valid = bu.out_valid;
      o.out_last = bu.out_last; o.busy = bu.busy; o.out_data = bu.out_data;
    end else begin
      o.mat_err = bs.mat_err; o.in_ready = bs.in_ready; o.out_valid = bs.out_valid;
      o.out_last = bs.out_last; o.busy = bs.busy; o.out_data = bs.out_data;
    end
    return o;
  endfunction

  function automatic int val(input int sel, input int raw);
    logic [EW-1:0] r;
    r = raw[EW-1:0];
    return (sel != 0) ? int'($signed(r)) : int'(r);
  endfunction

  task automatic set_in(input int sel, input logic v, input int d);
    if (sel == 0) begin bu.in_valid = v; bu.in_data = d[EW-1:0]; end
    else          begin bs.in_valid = v; bs.in_data = d[EW-1:0]; end
  endtask

  task automatic set_mat(input int sel, input logic we, input int a, input int d);
    if (sel == 0) begin bu.mat_we = we; bu.mat_addr = a[AW-1:0]; bu.mat_wdata = d[EW-1:0]; end
    else          begin bs.mat_we = we; bs.mat_addr = a[AW-1:0]; bs.mat_wdata = d[EW-1:0]; end
  endtask

  task automatic set_ordy(input int sel, input logic r);
    if (sel == 0) bu.out_ready = r;
    else          bs.out_ready = r;
  endtask

  task automatic write_mat(input int sel, input int a, input int d);
    set_mat(sel, 1'b1, a, d);
    @(negedge clk);
    set_mat(sel, 1'b0, 0, 0);
    mm[sel][a] = d & ((1 << EW) - 1);
  endtask

  task automatic check_reset_outputs(input int sel, input string pfx);
    obs_t o;
    o = sample(sel);
    chk({pfx, "_in_ready"},  o.in_ready,  0);
    chk({pfx, "_out_valid"}, o.out_valid, 0);
    chk({pfx, "_out_last"},  o.out_last,  0);
    chk({pfx, "_out_data"},  o.out_data,  0);
    chk({pfx, "_busy"},      o.busy,      0);
    chk({pfx, "_mat_err"},   o.mat_err,   0);
  endtask

  task automatic send_vec(input int sel, input int x[N]);
    exp_t e;
    int   t;
    for (int r = 0; r < N; r++) begin
      int sum;
      logic [31:0] s32;
      sum = 0;
      for (int c = 0; c < N; c++) sum += val(sel, mm[sel][r*N+c]) * val(sel, x[c]);
      s32    = sum;
      e.data = s32[RW-1:0];
      e.last = (r == N-1);
      sb.push_back(e);
    end
    for (int i = 0; i < N; i++) begin
      set_in(sel, 1'b1, x[i]);
      t = 0;
      while (!sample(sel).in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("in_ready_wait%0d", i), (t < 20), 1);
      @(negedge clk);
    end
    set_in(sel, 1'b0, 0);
  endtask

  task automatic recv_vec(input int sel, input int stall, input bit check_lat);
    obs_t          o;
    exp_t          e;
    int            w;
    logic [RW-1:0] first;
    set_ordy(sel, stall == 0);
    w = 1;
    while (!sample(sel).out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("out_valid_wait", (w < 100), 1);
    if (check_lat) chk("latency", w, NN + 1);
    if (stall > 0) begin
      first = sample(sel).out_data;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        o = sample(sel);
        chk($sformatf("stall%0d_valid", s), o.out_valid, 1);
        chk($sformatf("stall%0d_data", s), o.out_data, first);
      end
      set_ordy(sel, 1'b1);
    end
    for (int b = 0; b < N; b++) begin
      o = sample(sel);
      chk($sformatf("y%0d_valid", b), o.out_valid, 1);
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("y%0d_data", b), o.out_data, e.data);
        chk($sformatf("y%0d_last", b), o.out_last, e.last);
      end
      @(negedge clk);
    end
    set_ordy(sel, 1'b0);
    o = sample(sel);
    chk("drain_done_valid", o.out_valid, 0);
    chk("drain_done_busy",  o.busy,      0);
  endtask

  initial begin
    obs_t o;
    for (int s = 0; s < 2; s++) begin
      set_in(s, 1'b0, 0);
      set_mat(s, 1'b0, 0, 0);
      set_ordy(s, 1'b0);
      for (int i = 0; i < NN; i++) mm[s][i] = 0;
    end

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs(0, "rst_u");
    check_reset_outputs(1, "rst_s");
    rst = 1'b0;
    @(negedge clk);

    // Identity matrix, latency and out_last position
    for (int i = 0; i < N; i++) write_mat(0, i*N+i, 1);
    xv = '{1, 2, 3, 0};
    send_vec(0, xv);
    recv_vec(0, 0, 1'b1);

    // All-3 matrix at the unsigned maximum
    for (int i = 0; i < NN; i++) write_mat(0, i, 3);
    xv = '{3, 3, 3, 3};
    send_vec(0, xv);
    recv_vec(0, 0, 1'b0);

    // Backpressure: hold out_ready low for 10 DRAIN cycles
    write_mat(0, 0, 1);
    send_vec(0, xv);
    recv_vec(0, 10, 1'b0);

    // Matrix write during COMPUTE is dropped and flagged
    xv = '{1, 1, 1, 1};
    send_vec(0, xv);
    set_mat(0, 1'b1, 5, 0);
    #1;
    o = sample(0);
    chk("compute_mat_err", o.mat_err, 1);
    chk("compute_busy", o.busy, 1);
    chk("compute_in_ready", o.in_ready, 0);
    @(negedge clk);
    set_mat(0, 1'b0, 0, 0);
    #1;
    chk("mat_err_pulse_end", sample(0).mat_err, 0);
    @(negedge clk);
    recv_vec(0, 0, 1'b0);
    xv = '{2, 1, 0, 3};
    send_vec(0, xv);
    recv_vec(0, 0, 1'b0);

    // Signed operands
    for (int i = 0; i < NN; i++) write_mat(1, i, 2);
    xv = '{2, 2, 2, 2};
    send_vec(1, xv);
    recv_vec(1, 0, 1'b1);
    write_mat(1, 0, 1);
    write_mat(1, 1, 3);
    write_mat(1, 2, 1);
    write_mat(1, 3, 3);
    xv = '{1, 1, 1, 1};
    send_vec(1, xv);
    recv_vec(1, 0, 1'b0);

    // Reset in the middle of COMPUTE, then a fresh vector against a cleared matrix
    xv = '{3, 2, 1, 3};
    send_vec(0, xv);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(0, "midrst_u");
    rst = 1'b0;
    sb.delete();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NN; i++) mm[s][i] = 0;
    @(negedge clk);
    write_mat(0, 0, 2);
    write_mat(0, 5, 1);
    xv = '{1, 2, 3, 1};
    send_vec(0, xv);
    recv_vec(0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
